ram_fifo_ctrl: RTL
==================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of data words and both RAM data buses.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width; FIFO depth is 2**ADDR_W = 16.
REQ-003 SHALL have parameter AF_LEVEL, default 14, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have one clock, clk, and a synchronous active-high reset, rst; both ports are listed first.
REQ-006 Ports SHALL be: clk in 1, system clock, all state on rising edge | rst in 1, synchronous active-high reset.
REQ-007 Ports SHALL be: push in 1, write request | din in DATA_W, write data | full out 1, no free entry.
REQ-008 Ports SHALL be: pop in 1, read request | dout out DATA_W, read data | dout_valid out 1, dout holds new word | empty out 1, no stored entry.
REQ-009 Ports SHALL be: count out ADDR_W+1, stored entries, range 0..16.
REQ-010 Write-port ports SHALL be: wr_0 out 1 | rd_0 out 1 | addr_0 out ADDR_W | data_0 inout DATA_W.
REQ-011 Read-port ports SHALL be: wr_1 out 1 | rd_1 out 1 | addr_1 out ADDR_W | data_1 inout DATA_W.
REQ-012 Ports SHALL be: almost_full out 1, almost_empty out 1; these exist only under RAM_FIFO_ALMOST_EN.

Function
REQ-013 SHALL accept a write (wr_acc) when push=1 and full=0; any other push SHALL be ignored without error.
REQ-014 During wr_acc, wr_0 SHALL be 1, addr_0 SHALL equal wptr, and data_0 SHALL be driven with din; the RAM captures on that rising edge.
REQ-015 data_0 SHALL be high-Z whenever wr_0=0; rd_0 SHALL be tied 0.
REQ-016 SHALL accept a read (rd_acc) when pop=1 and empty=0; rd_1 SHALL then be 1 and addr_1 SHALL equal rptr.
REQ-017 wr_1 SHALL be tied 0, and data_1 SHALL never be driven by this block.
REQ-018 At the rising edge ending an rd_acc cycle, dout SHALL capture data_1 and dout_valid SHALL be 1 for exactly the next cycle. Read latency is 1 cycle.
REQ-019 dout SHALL hold its last value when no read is accepted.
REQ-020 wptr and rptr SHALL increment by 1 on their accepted operation and wrap from 15 to 0.
REQ-021 count SHALL update as: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
REQ-022 full SHALL equal (count==16), and empty SHALL equal (count==0); both are combinational from count.
REQ-023 Push and pop while empty: only the write SHALL be accepted, with no bypass to dout; count becomes 1.
REQ-024 Push and pop while full: only the read SHALL be accepted; count becomes 15.
REQ-025 wr_0 and rd_1 SHALL be combinational from push/pop and registered flags, with no added cycle.

Reset
REQ-026 On a rising edge with rst=1, wptr, rptr, and count SHALL become 0, dout SHALL become 0, and dout_valid SHALL become 0.
REQ-027 Reset SHALL override push and pop in the same cycle, including reset in the middle of a burst. RAM contents are not cleared.
REQ-028 After reset, empty SHALL be 1 and full SHALL be 0. While rst=1, wr_0 and rd_1 SHALL be 0.

Configuration
REQ-029 With RAM_FIFO_ALMOST_EN defined, the almost_full and almost_empty ports SHALL exist.
REQ-030 Under RAM_FIFO_ALMOST_EN, almost_full SHALL equal (count>=AF_LEVEL), and almost_empty SHALL equal (count<=AE_LEVEL).
REQ-031 Without RAM_FIFO_ALMOST_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Write, then read back: after reset, push 0x00..0x0F on 16 cycles, then pop 16 times. Required: addr_0 runs 0..15, full=1 after the 16th push, and dout reads 0x00..0x0F, each one cycle after its pop.
REQ-033 Full boundary: while full, push 0xAA with pop=0. Required: wr_0 stays 0 and count stays 16; then push 0xBB with pop=1, and count becomes 15 with no write.
REQ-034 Empty boundary: while empty, pop=1 with push=0. Required: rd_1=0 and dout_valid=0; then push 0x55 with pop=1, and count becomes 1 and dout is unchanged.
REQ-035 Wrap-around: push 20 words while popping after the 4th. Required: wptr wraps 15->0, the data order is preserved, and data_0 is Z on every idle cycle.
REQ-036 Reset mid-burst: assert rst with count=7 and push=1. Required: count=0, empty=1, and dout_valid=0 on the next cycle; the next push writes addr_0=0.
REQ-037 With RAM_FIFO_ALMOST_EN defined, fill to 14. Required: almost_full rises at count=14, and almost_empty falls at count=3.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
//   FIFO controller that keeps its storage in an external two-port RAM.
//   Port 0 of the RAM is used for writes only, port 1 for reads only. The RAM
//   captures a write on the rising edge that ends a write cycle. Its read port
//   returns data_1 combinationally from addr_1, and this block registers that
//   word into dout.
//
//   Optional feature: define RAM_FIFO_ALMOST_EN to add the almost_full and
//   almost_empty outputs.
//
// Handshake: a push is accepted when push=1 and full=0, and a pop is accepted
//   when pop=1 and empty=0. A request that is not accepted is dropped
//   silently. It is not held over to a later cycle. An accepted pop
//   presents dout with dout_valid=1 on the cycle that follows the pop.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   push, din, full   : write request, write data, no free entry
//   pop, dout,
//   dout_valid, empty : read request, read data, new-word strobe, no entry
//   count             : stored entries, 0..2**ADDR_W
//   almost_full,
//   almost_empty      : level flags (RAM_FIFO_ALMOST_EN only)
//   wr_0, rd_0,
//   addr_0, data_0    : RAM write port (rd_0 tied 0; data_0 Z unless writing)
//   wr_1, rd_1,
//   addr_1, data_1    : RAM read port (wr_1 tied 0; data_1 only sampled)

module ram_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
`ifdef RAM_FIFO_ALMOST_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              wr_0,
  output logic              rd_0,
  output logic [ADDR_W-1:0] addr_0,
  inout  wire  [DATA_W-1:0] data_0,
  output logic              wr_1,
  output logic              rd_1,
  output logic [ADDR_W-1:0] addr_1,
  inout  wire  [DATA_W-1:0] data_1
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1) << ADDR_W;

  // Elaboration-time sanity check on the level thresholds.
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("ram_fifo_ctrl: AE_LEVEL must be below AF_LEVEL");
  end

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              wr_acc, rd_acc;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Reset gates acceptance, so the RAM never sees a strobe while rst=1.
  // There is no bypass when the FIFO is empty: push+pop with empty=1 accepts
  // only the write.
  assign wr_acc = !rst && push && !full;
  assign rd_acc = !rst && pop && !empty;

  assign wr_0   = wr_acc;
  assign rd_0   = 1'b0;
  assign addr_0 = wptr_q;
  assign data_0 = wr_0 ? din : {DATA_W{1'bz}};

  assign wr_1   = 1'b0;
  assign rd_1   = rd_acc;
  assign addr_1 = rptr_q;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = rd_acc;
    if (wr_acc) wptr_d = wptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rptr_d = rptr_q + ADDR_W'(1);
      dout_d = data_1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef RAM_FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);

  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
`endif

endmodule
